wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the two physical-register-file write ports among four writeback requesters: arith lanes 0/1 (requesters 0/1) and mem lanes 0/1 (requesters 2/3).
- Sits between the execute stages and the register file / active-list completion logic.
- Arbitration is round-robin with valid/ready backpressure, and grants are registered with a 1-cycle latency.
- On a branch recall, writebacks younger than the mispredicted branch are dropped.

Parameters:
- N_REQ, 4, number of writeback requesters (fixed at 4 for this revision).
- N_PORT, 2, number of register-file write ports.
- DATA_W, 32, writeback data width.
- RD_W, 6, physical destination register index width.
- AL_SIZE, 32, active-list entries; AL_W = $clog2(AL_SIZE).
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  requester i presents a writeback.
- req_al_idx  input  N_REQ*AL_W  active-list index, packed by requester.
- req_rd  input  N_REQ*RD_W  destination physical register.
- req_uses_rd  input  N_REQ  instruction writes rd.
- req_data  input  N_REQ*DATA_W  result data.
- req_ready  output  N_REQ  combinational; accepted this cycle (granted or squashed).
- if_recall  input  1  branch mispredict recall this cycle.
- new_front  input  AL_W  active-list index of the mispredicted branch.
- old_front  input  AL_W  current active-list front pointer.
- wb_valid  output  N_PORT  registered write-port valid.
- wb_al_idx  output  N_PORT*AL_W  registered.
- wb_rd  output  N_PORT*RD_W  registered.
- wb_uses_rd  output  N_PORT  registered.
- wb_data  output  N_PORT*DATA_W  registered.
- contention_cnt  output  CNT_W  saturating count of cycles in which any valid, non-squashed request was refused.

Behaviour:
- Reset (async, active-high):
  - All wb_* outputs are 0.
  - rr_ptr = 0.
  - contention_cnt = 0.
  - req_ready is 0 while reset is asserted.
- Squash test (combinational, wrap-aware):
  - d(x) = (x - new_front) mod AL_SIZE.
  - Request i is squashed iff if_recall && 0 < d(al_idx_i) < d(old_front).
  - The branch itself (d = 0) is never squashed.
  - When old_front == new_front, nothing is squashed.
- Eligible = req_valid & ~squashed.
- Grant selection:
  - Scan requesters in order rr_ptr, rr_ptr+1, ... mod N_REQ.
  - The first eligible requester goes to port 0, the second to port 1.
  - At most N_PORT grants per cycle.
- req_ready[i] = granted[i] | (req_valid[i] & squashed[i]).
  - Squashed requests are accepted and discarded and do not consume a port.
- Handshake:
  - Transfer occurs when req_valid & req_ready.
  - A requester with valid=1 and ready=0 holds valid and its payload stable until accepted.
  - The arbiter does not rely on payload stability across cycles; it re-evaluates every cycle.
- Output timing:
  - On the next posedge clk, wb_valid[p] = 1 with the payload of the requester granted port p; otherwise wb_valid[p] = 0.
  - Unused ports carry wb_* = 0 (data zeroed, not held).
  - Latency is exactly 1 cycle. There is no output backpressure; the register file always accepts.
- Round-robin update:
  - If at least one grant is made, rr_ptr <= (index of last granted requester + 1) mod N_REQ.
  - If no grant is made, rr_ptr is unchanged.
  - Guarantees any continuously eligible requester is granted within 2 cycles.
- contention_cnt increments by 1 in any cycle where the number of eligible requesters exceeds N_PORT, and saturates at 2^CNT_W - 1.
- Recall and register-file pipeline: a recall does not retroactively cancel wb_* already registered in the previous cycle; downstream recall logic handles those.
- Simultaneous events: a recall in the same cycle as 4 valid requests uses the squash test first, then arbitrates among the remaining eligible requesters.
- Reset asserted mid-operation clears outputs immediately (async); pending requests are lost.

Test Plan:
- Reset: assert reset with all 4 requests valid -> wb_valid=00, req_ready=0000, contention_cnt=0. Release reset -> first grants are to req0 (port 0) and req1 (port 1).
- Single request: req2 valid, al_idx=5, rd=9, data=0xDEADBEEF, uses_rd=1 -> req_ready=0100. Next cycle: wb_valid=01, port 0 carries al_idx 5, rd 9, data 0xDEADBEEF; port 1 all zeros.
- Fairness: all 4 requests held valid for 4 cycles starting at rr_ptr=0 -> grant pairs in order {0,1}, {2,3}, {0,1}, {2,3}; contention_cnt=4.
- Wrap-around grant: rr_ptr=3, req3 and req0 valid -> port 0 = req3, port 1 = req0; rr_ptr becomes 1.
- Wrapped squash: if_recall=1, new_front=30, old_front=3, with req0 al_idx=31, req1 al_idx=1, req2 al_idx=30, req3 al_idx=10 ->
  - req0 and req1 are squashed (ready=1, not written).
  - req2 and req3 are granted to ports 0/1.
  - wb_valid=11 next cycle with al_idx 30 and 10.
- Saturation: force contention for 2^16+5 cycles -> contention_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin share of N_PORT regfile write ports among N_REQ writeback requesters (req_* in, req_ready out, registered wb_* out, recall squash, contention_cnt)
module wb_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_PORT  = 2,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 6,
  parameter int AL_SIZE = 32,
  parameter int CNT_W   = 16,
  localparam int AL_W   = $clog2(AL_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*AL_W-1:0]    req_al_idx,
  input  logic [N_REQ*RD_W-1:0]    req_rd,
  input  logic [N_REQ-1:0]         req_uses_rd,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     if_recall,
  input  logic [AL_W-1:0]          new_front,
  input  logic [AL_W-1:0]          old_front,
  output logic [N_PORT-1:0]        wb_valid,
  output logic [N_PORT*AL_W-1:0]   wb_al_idx,
  output logic [N_PORT*RD_W-1:0]   wb_rd,
  output logic [N_PORT-1:0]        wb_uses_rd,
  output logic [N_PORT*DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]         contention_cnt
);
  localparam int RR_W = $clog2(N_REQ);
  localparam int CW   = $clog2(N_REQ + 1);
  logic [AL_W-1:0] d_old, d_i;
  logic [N_REQ-1:0] sq, elig, gnt;
  logic [RR_W-1:0] rr_q, rr_d, idx, last;
  logic [RR_W-1:0] sel [N_PORT];
  logic [N_PORT-1:0] sel_v;
  logic [CW-1:0] n_elig;
  logic taken;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_PORT-1:0] wb_valid_q, wb_valid_d, wb_uses_rd_q, wb_uses_rd_d;
  logic [N_PORT*AL_W-1:0] wb_al_idx_q, wb_al_idx_d;
  logic [N_PORT*RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [N_PORT*DATA_W-1:0] wb_data_q, wb_data_d;
  always_comb begin
    d_old = old_front - new_front;
    d_i = '0;
    sq = '0;
    gnt = '0;
    sel_v = '0;
    n_elig = '0;
    last = rr_q;
    idx = '0;
    taken = 1'b0;
    for (int p = 0; p < N_PORT; p++) sel[p] = '0;
    for (int i = 0; i < N_REQ; i++) begin
      d_i = req_al_idx[i*AL_W +: AL_W] - new_front;
      sq[i] = if_recall && d_i != '0 && d_i < d_old;
    end
    elig = req_valid & ~sq;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_q + RR_W'(k);
      taken = 1'b0;
      if (elig[idx]) begin
        n_elig = n_elig + 1'b1;
        for (int p = 0; p < N_PORT; p++)
          if (!taken && !sel_v[p]) begin
            sel_v[p] = 1'b1;
            sel[p] = idx;
            taken = 1'b1;
          end
        if (taken) begin
          gnt[idx] = 1'b1;
          last = idx;
        end
      end
    end
    rr_d = |gnt ? last + 1'b1 : rr_q;
    cnt_d = (n_elig > CW'(N_PORT) && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    wb_valid_d = sel_v;
    wb_uses_rd_d = '0;
    wb_al_idx_d = '0;
    wb_rd_d = '0;
    wb_data_d = '0;
    for (int p = 0; p < N_PORT; p++) begin
      wb_uses_rd_d[p] = sel_v[p] & req_uses_rd[sel[p]];
      wb_al_idx_d[p*AL_W +: AL_W] = sel_v[p] ? req_al_idx[sel[p]*AL_W +: AL_W] : '0;
      wb_rd_d[p*RD_W +: RD_W] = sel_v[p] ? req_rd[sel[p]*RD_W +: RD_W] : '0;
      wb_data_d[p*DATA_W +: DATA_W] = sel_v[p] ? req_data[sel[p]*DATA_W +: DATA_W] : '0;
    end
  end
  assign req_ready = reset ? '0 : gnt | (req_valid & sq);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
      cnt_q <= '0;
      wb_valid_q <= '0;
      wb_uses_rd_q <= '0;
      wb_al_idx_q <= '0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
    end else begin
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_uses_rd_q <= wb_uses_rd_d;
      wb_al_idx_q <= wb_al_idx_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end
  assign wb_valid = wb_valid_q;
  assign wb_uses_rd = wb_uses_rd_q;
  assign wb_al_idx = wb_al_idx_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign contention_cnt = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for wb_port_arbiter against a queue-based reference model
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0, req_uses_rd = '0, req_ready;
  logic [19:0] req_al_idx = '0;
  logic [23:0] req_rd = '0;
  logic [127:0] req_data = '0;
  logic if_recall = 1'b0;
  logic [4:0] new_front = '0, old_front = '0;
  logic [1:0] wb_valid, wb_uses_rd;
  logic [9:0] wb_al_idx;
  logic [11:0] wb_rd;
  logic [63:0] wb_data;
  logic [15:0] contention_cnt;
  wb_port_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_al_idx(req_al_idx), .req_rd(req_rd),
    .req_uses_rd(req_uses_rd), .req_data(req_data), .req_ready(req_ready), .if_recall(if_recall),
    .new_front(new_front), .old_front(old_front), .wb_valid(wb_valid), .wb_al_idx(wb_al_idx),
    .wb_rd(wb_rd), .wb_uses_rd(wb_uses_rd), .wb_data(wb_data), .contention_cnt(contention_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0] v;
    logic [9:0] al;
    logic [11:0] rd;
    logic [1:0] ur;
    logic [63:0] data;
    logic [15:0] cnt;
  } wb_t;
  wb_t wbq[$];
  logic [3:0] rdyq[$];
  int total = 0, bad = 0;
  bit mon_en = 1'b0;
  logic [3:0] s_v = '0, s_ur = '0, m_rdy;
  logic [4:0] s_al [4];
  logic [5:0] s_rd [4];
  logic [31:0] s_data [4];
  logic s_rec = 1'b0;
  logic [4:0] s_nf = '0, s_of = '0;
  int m_rr = 0, m_cnt = 0;
  bit pend [4];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (rdyq.size() == 0) chk("ready_queue_empty", 64'd1, 64'd0);
      else chk("req_ready", 64'(req_ready), 64'(rdyq.pop_front()));
    end
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (wbq.size() == 0) chk("wb_queue_empty", 64'd1, 64'd0);
      else begin
        wb_t e;
        e = wbq.pop_front();
        chk("wb_valid", 64'(wb_valid), 64'(e.v));
        chk("wb_al_idx", 64'(wb_al_idx), 64'(e.al));
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_uses_rd", 64'(wb_uses_rd), 64'(e.ur));
        chk("wb_data", wb_data, e.data);
        chk("contention_cnt", 64'(contention_cnt), 64'(e.cnt));
      end
    end
  end
  task automatic step();
    int dold, d, ng, idx;
    int el[$];
    logic [3:0] sq;
    wb_t e;
    for (int i = 0; i < 4; i++) begin
      req_al_idx[i*5 +: 5] = s_al[i];
      req_rd[i*6 +: 6] = s_rd[i];
      req_data[i*32 +: 32] = s_data[i];
    end
    req_valid = s_v;
    req_uses_rd = s_ur;
    if_recall = s_rec;
    new_front = s_nf;
    old_front = s_of;
    dold = (int'(s_of) - int'(s_nf) + 32) % 32;
    for (int i = 0; i < 4; i++) begin
      d = (int'(s_al[i]) - int'(s_nf) + 32) % 32;
      sq[i] = s_rec && d > 0 && d < dold;
    end
    for (int k = 0; k < 4; k++) begin
      idx = (m_rr + k) % 4;
      if (s_v[idx] && !sq[idx]) el.push_back(idx);
    end
    ng = el.size() > 2 ? 2 : el.size();
    m_rdy = s_v & sq;
    e = '0;
    for (int p = 0; p < ng; p++) begin
      m_rdy[el[p]] = 1'b1;
      e.v[p] = 1'b1;
      e.al[p*5 +: 5] = s_al[el[p]];
      e.rd[p*6 +: 6] = s_rd[el[p]];
      e.ur[p] = s_ur[el[p]];
      e.data[p*32 +: 32] = s_data[el[p]];
    end
    if (ng > 0) m_rr = (el[ng-1] + 1) % 4;
    if (el.size() > 2 && m_cnt < 65535) m_cnt++;
    e.cnt = 16'(m_cnt);
    rdyq.push_back(m_rdy);
    wbq.push_back(e);
    @(negedge clk);
  endtask
  task automatic set_req(input int i, input logic [4:0] al, input logic [5:0] rd, input logic [31:0] dt, input logic ur);
    s_v[i] = 1'b1;
    s_al[i] = al;
    s_rd[i] = rd;
    s_data[i] = dt;
    s_ur[i] = ur;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      s_al[i] = '0;
      s_rd[i] = '0;
      s_data[i] = '0;
      pend[i] = 1'b0;
    end
    req_valid = 4'hF;
    #12;
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_cnt", 64'(contention_cnt), 64'd0);
    chk("reset_wb_data", wb_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 6'(i + 10), 32'h1000 + 32'(i), 1'b1);
    repeat (4) step();
    s_v = '0;
    set_req(2, 5'd5, 6'd9, 32'hDEADBEEF, 1'b1);
    step();
    s_v = '0;
    set_req(3, 5'd7, 6'd3, 32'h33333333, 1'b0);
    set_req(0, 5'd8, 6'd4, 32'h00000000, 1'b1);
    step();
    s_v = '0;
    set_req(0, 5'd31, 6'd1, 32'hA0, 1'b1);
    set_req(1, 5'd1, 6'd2, 32'hA1, 1'b1);
    set_req(2, 5'd30, 6'd3, 32'hA2, 1'b1);
    set_req(3, 5'd10, 6'd4, 32'hA3, 1'b1);
    s_rec = 1'b1;
    s_nf = 5'd30;
    s_of = 5'd3;
    step();
    s_v = '0;
    s_nf = 5'd12;
    s_of = 5'd12;
    set_req(0, 5'd13, 6'd5, 32'hB0, 1'b0);
    set_req(1, 5'd12, 6'd6, 32'hB1, 1'b1);
    step();
    s_rec = 1'b0;
    s_v = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          s_al[i] = 5'($urandom_range(0, 31));
          s_rd[i] = 6'($urandom);
          s_data[i] = $urandom;
          s_ur[i] = 1'($urandom);
        end
      for (int i = 0; i < 4; i++) s_v[i] = pend[i];
      s_rec = $urandom_range(0, 3) == 0;
      s_nf = 5'($urandom);
      s_of = 5'($urandom);
      step();
      for (int i = 0; i < 4; i++) if (m_rdy[i]) pend[i] = 1'b0;
    end
    s_rec = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i), 6'(i), 32'hC0 + 32'(i), 1'b1);
    repeat (65541) step();
    mon_en = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_wb_valid", 64'(wb_valid), 64'd0);
    chk("midreset_wb_data", wb_data, 64'd0);
    chk("midreset_ready", 64'(req_ready), 64'd0);
    chk("midreset_cnt", 64'(contention_cnt), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
